// File: rtl/lfsr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_gen
//  Description : Parametrised LFSR pseudo-random generator. Fibonacci or
//                Galois form is selected at run time. It has a step enable,
//                a period counter with a wrap pulse and all-zero lockup
//                detection.
//                Optional build macro: LFSR_LOCKUP_RECOVER_EN. When it is
//                defined, an enabled step taken from the all-zero state
//                reseeds the generator with SEED.
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_gen #(
    parameter int                 WIDTH    = 26,
    parameter logic [WIDTH-1:0]   FIB_TAPS = 26'h2000023,
    parameter logic [WIDTH-1:0]   GAL_TAPS = 26'h0000047,
    parameter logic [WIDTH-1:0]   SEED     = {{(WIDTH-1){1'b0}}, 1'b1},
    parameter int                 CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              load,
    input  logic              mode,
    input  logic [WIDTH-1:0]  din,
    output logic [WIDTH-1:0]  q,
    output logic              serial_out,
    output logic              wrap,
    output logic [CNT_W-1:0]  period,
    output logic              lockup
);

    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] q_q,      q_d;
    logic [WIDTH-1:0] seed_q,   seed_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             wrap_q,   wrap_d;

    logic             w_fib_fb;
    logic [WIDTH-1:0] w_fib_next;
    logic [WIDTH-1:0] w_gal_next;
    logic [WIDTH-1:0] w_step_next;
    logic             w_zero;
    logic [CNT_W-1:0] w_cnt_inc;

    // Candidate next states for both LFSR forms; mode picks one per step
    always_comb begin
        w_fib_fb    = ^(q_q & FIB_TAPS);
        w_fib_next  = {q_q[WIDTH-2:0], w_fib_fb};
        w_gal_next  = {q_q[WIDTH-2:0], 1'b0} ^ (q_q[WIDTH-1] ? GAL_TAPS : {WIDTH{1'b0}});
        w_step_next = mode ? w_gal_next : w_fib_next;
        w_zero      = (q_q == {WIDTH{1'b0}});
        // Saturating increment, so a very long sequence never reports a wrapped count
        w_cnt_inc   = (cnt_q == C_CNT_MAX) ? cnt_q : (cnt_q + C_CNT_ONE);
    end

    // Next-state selection: load beats en, and no enable means hold
    always_comb begin
        q_d      = q_q;
        seed_d   = seed_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        wrap_d   = 1'b0;
        if (load) begin
            q_d    = din;
            seed_d = din;
            cnt_d  = {CNT_W{1'b0}};
        end else if (en) begin
            if (w_zero) begin
`ifdef LFSR_LOCKUP_RECOVER_EN
                q_d    = SEED;
                seed_d = SEED;
                cnt_d  = {CNT_W{1'b0}};
`else
                q_d    = q_q;
`endif
            end else begin
                q_d = w_step_next;
                if (w_step_next == seed_q) begin
                    // The step count includes the step that lands back on the seed
                    period_d = w_cnt_inc;
                    cnt_d    = {CNT_W{1'b0}};
                    wrap_d   = 1'b1;
                end else begin
                    cnt_d    = w_cnt_inc;
                end
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q      <= SEED;
            seed_q   <= SEED;
            cnt_q    <= {CNT_W{1'b0}};
            period_q <= {CNT_W{1'b0}};
            wrap_q   <= 1'b0;
        end else begin
            q_q      <= q_d;
            seed_q   <= seed_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            wrap_q   <= wrap_d;
        end
    end

    assign q          = q_q;
    assign serial_out = q_q[WIDTH-1];
    assign wrap       = wrap_q;
    assign period     = period_q;
    assign lockup     = w_zero;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lfsr_gen
//  Description : Self-checking bench for lfsr_gen. It covers a 4-bit instance
//                (directed sequences plus random control) and a default
//                26-bit instance (long run in both forms).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- 4-bit instance ----------------
    logic        rst_n_a = 1'b0, en_a = 1'b0, load_a = 1'b0, mode_a = 1'b0;
    logic [3:0]  din_a = 4'd0, q_a;
    logic        so_a, wrap_a, lock_a;
    logic [31:0] per_a;

    lfsr_gen #(
        .WIDTH(4), .FIB_TAPS(4'b1100), .GAL_TAPS(4'b0011), .SEED(4'b0001), .CNT_W(32)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n_a), .en(en_a), .load(load_a), .mode(mode_a),
        .din(din_a), .q(q_a), .serial_out(so_a), .wrap(wrap_a),
        .period(per_a), .lockup(lock_a)
    );

    // ---------------- 26-bit default instance ----------------
    logic        rst_n_b = 1'b0, en_b = 1'b0, load_b = 1'b0, mode_b = 1'b0;
    logic [25:0] din_b = 26'd0, q_b;
    logic        so_b, wrap_b, lock_b;
    logic [31:0] per_b;

    lfsr_gen u_dut_b (
        .clk(clk), .rst_n(rst_n_b), .en(en_b), .load(load_b), .mode(mode_b),
        .din(din_b), .q(q_b), .serial_out(so_b), .wrap(wrap_b),
        .period(per_b), .lockup(lock_b)
    );

    // ---------------- reference model ----------------
    // Fibonacci: the new bit is the parity of the tapped bits.
    function automatic logic [3:0] fib4(input logic [3:0] v);
        int ones = $countones(v & 4'b1100);
        logic b = (ones % 2) == 1;
        return {v[2:0], b};
    endfunction

    // Galois: multiply by x modulo x^4 + x + 1.
    function automatic logic [3:0] gal4(input logic [3:0] v);
        logic [4:0] t = {v, 1'b0};
        if (t[4]) t = t ^ 5'b10011;
        return t[3:0];
    endfunction

    function automatic logic [25:0] fib26(input logic [25:0] v);
        int ones = $countones(v & 26'h2000023);
        logic b = (ones % 2) == 1;
        return {v[24:0], b};
    endfunction

    // Galois: multiply by x modulo x^26 + x^6 + x^2 + x + 1.
    function automatic logic [25:0] gal26(input logic [25:0] v);
        logic [26:0] t = {v, 1'b0};
        if (t[26]) t = t ^ 27'h4000047;
        return t[25:0];
    endfunction

    logic [3:0]  mq, ms;
    logic [31:0] mc, mp;
    logic        mw;

    task automatic cyc_a(input logic r, input logic e, input logic l,
                         input logic m, input logic [3:0] d);
        logic [3:0] nxt;
        rst_n_a = r; en_a = e; load_a = l; mode_a = m; din_a = d;
        @(posedge clk);
        if (!r) begin
            mq = 4'd1; ms = 4'd1; mc = 0; mp = 0; mw = 1'b0;
        end else if (l) begin
            mq = d; ms = d; mc = 0; mw = 1'b0;
        end else if (e) begin
            mw = 1'b0;
            if (mq == 4'd0) begin
`ifdef LFSR_LOCKUP_RECOVER_EN
                mq = 4'd1; ms = 4'd1; mc = 0;
`endif
            end else begin
                nxt = m ? gal4(mq) : fib4(mq);
                if (nxt == ms) begin
                    mp = mc + 1; mc = 0; mw = 1'b1;
                end else if (mc != 32'hFFFF_FFFF) begin
                    mc = mc + 1;
                end
                mq = nxt;
            end
        end else begin
            mw = 1'b0;
        end
        #1;
        chk("q", q_a, mq);
        chk("wrap", wrap_a, mw);
        chk("period", per_a, mp);
        chk("lockup", lock_a, (mq == 4'd0));
        chk("serial_out", so_a, mq[3]);
    endtask

    logic [3:0] fib_tab [16] = '{4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110,
                                 4'b1101, 4'b1010, 4'b0101, 4'b1011, 4'b0111, 4'b1111,
                                 4'b1110, 4'b1100, 4'b1000, 4'b0001};
    logic [3:0] gal_tab [16] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b0110,
                                 4'b1100, 4'b1011, 4'b0101, 4'b1010, 4'b0111, 4'b1110,
                                 4'b1111, 4'b1101, 4'b1001, 4'b0001};

    initial begin
        logic [25:0] mb;
        logic        wrap_seen;
        logic [31:0] per_hold;

        // Reset
        cyc_a(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        cyc_a(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        chk("reset_q", q_a, 4'b0001);
        chk("reset_period", per_a, 32'd0);

        // Fibonacci sequence
        for (int i = 1; i < 16; i++) begin
            cyc_a(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
            chk("fib_seq", q_a, fib_tab[i]);
        end
        chk("fib_wrap", wrap_a, 1'b1);
        chk("fib_period", per_a, 32'd15);

        // Galois sequence, continuing from the seed
        for (int i = 1; i < 16; i++) begin
            cyc_a(1'b1, 1'b1, 1'b0, 1'b1, 4'd0);
            chk("gal_seq", q_a, gal_tab[i]);
        end
        chk("gal_wrap", wrap_a, 1'b1);
        chk("gal_period", per_a, 32'd15);

        // Enable gap, then load taking priority over en
        for (int i = 0; i < 5; i++) cyc_a(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        for (int i = 0; i < 5; i++) begin
            cyc_a(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
            chk("gap_q", q_a, fib_tab[5]);
        end
        cyc_a(1'b1, 1'b1, 1'b1, 1'b0, 4'b0110);
        chk("load_q", q_a, 4'b0110);
        for (int i = 0; i < 15; i++) cyc_a(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        chk("load_wrap", wrap_a, 1'b1);
        chk("load_wrap_q", q_a, 4'b0110);

        // Zero lockup
        per_hold = per_a;
        cyc_a(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
        chk("zero_lockup", lock_a, 1'b1);
        cyc_a(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
`ifdef LFSR_LOCKUP_RECOVER_EN
        chk("recover_q", q_a, 4'b0001);
        chk("recover_lockup", lock_a, 1'b0);
`else
        chk("stuck_q", q_a, 4'b0000);
        chk("stuck_lockup", lock_a, 1'b1);
`endif
        for (int i = 0; i < 9; i++) cyc_a(1'b1, 1'b1, 1'b0, 1'($urandom_range(0, 1)), 4'd0);
`ifndef LFSR_LOCKUP_RECOVER_EN
        chk("stuck_period", per_a, per_hold);
`endif

        // Reset in mid-operation
        cyc_a(1'b1, 1'b0, 1'b1, 1'b0, 4'b1001);
        for (int i = 0; i < 4; i++) cyc_a(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        cyc_a(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        chk("midreset_q", q_a, 4'b0001);
        chk("midreset_period", per_a, 32'd0);
        cyc_a(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        chk("restart_q", q_a, fib_tab[1]);

        // Random control traffic
        for (int i = 0; i < 400; i++) begin
            cyc_a(($urandom_range(0, 99) != 0),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 19) == 0),
                  1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)));
        end

        // Default 26-bit instance, both forms
        for (int m = 0; m < 2; m++) begin
            rst_n_b = 1'b0; en_b = 1'b0; load_b = 1'b0; mode_b = 1'(m); din_b = 26'd0;
            @(posedge clk); #1;
            chk("b_reset_q", q_b, 26'd1);
            rst_n_b = 1'b1; load_b = 1'b1; din_b = 26'd1;
            @(posedge clk); #1;
            load_b = 1'b0; en_b = 1'b1;
            mb = 26'd1;
            wrap_seen = 1'b0;
            for (int i = 0; i < 1000; i++) begin
                mb = (m == 1) ? gal26(mb) : fib26(mb);
                @(posedge clk); #1;
                if (wrap_b) wrap_seen = 1'b1;
            end
            en_b = 1'b0;
            chk("b_q_1000", q_b, mb);
            chk("b_lockup", lock_b, 1'b0);
            chk("b_no_wrap", wrap_seen, 1'b0);
            chk("b_serial", so_b, mb[25]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lfsr_gen.md
Name: lfsr_gen

Overview:
Parametrised LFSR pseudo-random generator. It is the next-generation replacement for the fixed 26-bit LFSR and adds the following:
- Configurable width and taps.
- Run-time selection between Fibonacci and Galois forms.
- A step enable.
- A period counter with a wrap pulse.
- All-zero lockup detection.

It sits in datapath/test logic as a PRBS source and a self-checking sequence generator.

Parameters:
- WIDTH, 26, register width in bits (>=3).
- FIB_TAPS, 26'h2000023, Fibonacci feedback mask; bit i set = q[i] XORed into feedback (x^26+x^6+x^2+x+1).
- GAL_TAPS, 26'h0000047, Galois mask; the XOR pattern applied after the shift when the msb is 1 (same polynomial).
- SEED, 1, reset value of q and of the seed register.
- CNT_W, 32, period counter and period output width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- en  in  1  advance one step this cycle
- load  in  1  load din into state and seed register (priority over en)
- mode  in  1  0 = Fibonacci, 1 = Galois
- din  in  WIDTH  load value
- q  out  WIDTH  current LFSR state
- serial_out  out  1  q[WIDTH-1]
- wrap  out  1  one-cycle pulse: the state just returned to the seed
- period  out  CNT_W  step count of the last completed cycle
- lockup  out  1  q is all-zero

Behaviour:
- clk and rst_n are the only clock and reset. Reset is synchronous and active-low; it is sampled on the rising edge of clk.
- Reset values:
  - q = SEED, seed_reg = SEED, cnt = 0.
  - period = 0, wrap = 0.
  - lockup = (SEED == 0).
- Priority each edge: rst_n low > load > en > hold.
- Fibonacci step: fb = XOR-reduce(q & FIB_TAPS); q_next = {q[WIDTH-2:0], fb}.
- Galois step: q_next = {q[WIDTH-2:0], 1'b0} ^ (q[WIDTH-1] ? GAL_TAPS : 0).
- mode is sampled on every enabled step. Changing mode mid-run takes effect on the next step with no flush, and cnt is not cleared.
- Load: q <= din, seed_reg <= din, cnt <= 0, wrap <= 0. period holds its value.
- Enabled step when q != 0:
  - If q_next == seed_reg: period <= cnt + 1, cnt <= 0, wrap <= 1.
  - Otherwise: cnt <= cnt + 1 (saturating at 2^CNT_W - 1), wrap <= 0.
- wrap is registered and coincides with q showing seed_reg. It is 0 on any cycle without an enabled step.
- en low: q, cnt and period hold; wrap <= 0.
- Lockup:
  - lockup = (q == 0), derived combinationally from the state register.
  - While q == 0, wrap and period never update and cnt holds.
- serial_out = q[WIDTH-1] at all times.
- Latency: one clock from an en, load or rst_n edge to the new q.

Optional Feature:
LFSR_LOCKUP_RECOVER_EN
- Defined: an enabled step with q == 0 instead loads q <= SEED, seed_reg <= SEED, cnt <= 0, wrap <= 0. lockup is high only for the cycle(s) q was zero.
- Undefined: q stays 0 through enabled steps, and lockup stays 1 until a load or reset.

Test Plan:
1. Fibonacci sequence. WIDTH=4, FIB_TAPS=4'b1100, SEED=1, mode=0, reset then en=1. Required q: 0001, 0010, 0100, 1001, 0011, 0110, 1101, 1010, 0101, 1011, 0111, 1111, 1110, 1100, 1000, 0001. wrap pulses with the 16th q (0001) and period = 15.
2. Galois sequence. WIDTH=4, GAL_TAPS=4'b0011, mode=1, from SEED=1. Required q: 0001, 0010, 0100, 1000, 0011, 0110, 1100, 1011, 0101, 1010, 0111, 1110, 1111, 1101, 1001, 0001. period = 15 after the wrap.
3. Enable gap and load priority.
   - Drop en for 5 cycles mid-sequence: q, cnt and period hold; wrap = 0.
   - Assert load with din=4'b0110 and en=1 together: q = 0110 next cycle and cnt = 0.
   - Run 15 more steps: wrap is seen when q returns to 0110.
4. Zero lockup.
   - Load din=0: lockup = 1 and q stays 0000 for 10 enabled steps; wrap never fires and period is unchanged (macro undefined).
   - With LFSR_LOCKUP_RECOVER_EN defined: the first enabled step gives q = 0001 and lockup = 0.
5. Reset mid-operation. Pull rst_n low for 1 cycle mid-sequence with en=1: q = SEED, period = 0, wrap = 0 on the next edge, and the sequence restarts from SEED.
6. Default parameters (WIDTH=26), load din=26'b1: after 1000 enabled steps, q matches a software model of x^26+x^6+x^2+x+1 in both modes, lockup = 0, and wrap has not fired.
